// File: rtl/mandel_pkg.sv
// Shared definitions for the Mandelbrot command path: opcodes, parameter
// width, payload length and parser state encoding.
package mandel_pkg;

  localparam logic [7:0]  OP_RENDER     = 8'h01;
  localparam logic [7:0]  OP_ABORT      = 8'h02;
  localparam int unsigned PARAM_W       = 16;
  localparam int unsigned PAYLOAD_BYTES = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_PENDING = 2'd2
  } parser_state_e;

  // Payload fields arrive most-significant byte first.
  function automatic logic [PARAM_W-1:0] be_word(input logic [7:0] hi,
                                                 input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/uart_cmd_parser.sv
// Frames opcode+payload command packets from the UART byte strobe, latches
// render parameters and hands them to the render core with a start pulse.
module uart_cmd_parser
  import mandel_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned PAYLOAD_BYTES  = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               i_rx_valid,
  input  logic [7:0]         i_rx_byte,
  input  logic               i_core_busy,
  output logic               o_start,
  output logic               o_abort,
  output logic [PARAM_W-1:0] o_x0,
  output logic [PARAM_W-1:0] o_y0,
  output logic [PARAM_W-1:0] o_step,
  output logic               o_err,
  output logic               o_drop
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned IDX_W = $clog2(PAYLOAD_BYTES);

  parser_state_e state_q, state_d;

  logic [IDX_W-1:0]                  idx_q, idx_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d, cnt_inc;
  logic [PAYLOAD_BYTES-1:0][7:0]     shadow_q, shadow_d, payload_w;
  logic                              last_byte, timeout_hit;

  logic               start_q, start_d;
  logic               abort_q, abort_d;
  logic               err_q, err_d;
  logic               drop_q, drop_d;
  logic [PARAM_W-1:0] x0_q, x0_d;
  logic [PARAM_W-1:0] y0_q, y0_d;
  logic [PARAM_W-1:0] step_q, step_d;

  assign last_byte   = (idx_q == IDX_W'(PAYLOAD_BYTES - 1));
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  // Shadow with the current byte merged in, so the final payload byte can
  // launch the core in the very next cycle without a detour via PENDING.
  always_comb begin
    payload_w = shadow_q;
    if (state_q == ST_PAYLOAD && i_rx_valid) begin
      payload_w[idx_q] = i_rx_byte;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_rx_valid && i_rx_byte == OP_RENDER) begin
          state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (i_rx_valid) begin
          if (last_byte) begin
            state_d = i_core_busy ? ST_PENDING : ST_IDLE;
          end
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
        end
      end
      ST_PENDING: begin
        if (!i_core_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    start_d  = 1'b0;
    abort_d  = 1'b0;
    err_d    = 1'b0;
    drop_d   = 1'b0;
    x0_d     = x0_q;
    y0_d     = y0_q;
    step_d   = step_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    shadow_d = payload_w;
    unique case (state_q)
      ST_IDLE: begin
        if (i_rx_valid) begin
          unique case (i_rx_byte)
            OP_RENDER: begin
              idx_d = '0;
              cnt_d = '0;
            end
            OP_ABORT: abort_d = 1'b1;
            default:  err_d   = 1'b1;
          endcase
        end
      end
      ST_PAYLOAD: begin
        if (i_rx_valid) begin
          idx_d = idx_q + IDX_W'(1);
          cnt_d = '0;
          if (last_byte && !i_core_busy) begin
            start_d = 1'b1;
            x0_d    = be_word(payload_w[0], payload_w[1]);
            y0_d    = be_word(payload_w[2], payload_w[3]);
            step_d  = be_word(payload_w[4], payload_w[5]);
          end
        end else begin
          cnt_d = cnt_inc;
          err_d = timeout_hit;
        end
      end
      ST_PENDING: begin
        drop_d = i_rx_valid;
        if (!i_core_busy) begin
          start_d = 1'b1;
          x0_d    = be_word(payload_w[0], payload_w[1]);
          y0_d    = be_word(payload_w[2], payload_w[3]);
          step_d  = be_word(payload_w[4], payload_w[5]);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      idx_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      start_q  <= 1'b0;
      abort_q  <= 1'b0;
      err_q    <= 1'b0;
      drop_q   <= 1'b0;
      x0_q     <= '0;
      y0_q     <= '0;
      step_q   <= '0;
    end else begin
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      start_q  <= start_d;
      abort_q  <= abort_d;
      err_q    <= err_d;
      drop_q   <= drop_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      step_q   <= step_d;
    end
  end

  assign o_start = start_q;
  assign o_abort = abort_q;
  assign o_err   = err_q;
  assign o_drop  = drop_q;
  assign o_x0    = x0_q;
  assign o_y0    = y0_q;
  assign o_step  = step_q;

endmodule
